mc_ctrl_unit: RTL and testbench

Multicycle control unit for the micro ARM core. It decodes instruction fields, drives the ALU operation select and the datapath enables, and consumes the ALU flag output.
- Holds the architectural NZCV register.
- Evaluates ARM condition codes.
- Sequences fetch/decode/execute/memory/writeback through a Moore FSM.

---
 rtl/mc_ctrl_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// mc_ctrl_unit
// Multicycle control unit for the micro ARM core. A Moore FSM sequences
// fetch / decode / execute / memory / writeback, drives the datapath
// selects and write enables, evaluates ARM condition codes against the
// architectural NZCV register it holds, and updates that register from
// the ALU flags when a flag-setting data-processing instruction executes.
//
// Optional feature macro: CTRL_CMP_EN
//   defined   : cmd 1010 (CMP) is legal. It subtracts, always updates flags
//               (subject to the condition) and never writes a register.
//   undefined : cmd 1010 is unsupported like any other unknown cmd.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   cond       in   [3:0] instruction condition field
//   op         in   [1:0] instruction class
//   funct      in   [5:0] {I, cmd[3:0], S/L}
//   rd         in   [3:0] destination register
//   alu_flags  in   [3:0] {N,Z,C,V} from the ALU, current cycle
//   pc_we      out  PC write enable
//   ir_we      out  instruction register write enable
//   reg_we     out  register file write enable
//   mem_we     out  data memory write enable
//   adr_src    out  0=PC, 1=ALU result register
//   alu_src_a  out  0=register A, 1=PC
//   alu_src_b  out  [1:0] 00=register B, 01=extended imm, 10=constant 4
//   result_src out  [1:0] 00=ALU result reg, 01=memory data, 10=ALU direct
//   imm_src    out  [1:0] equals op
//   alu_ctrl   out  [ALU_CTRL_W-1:0] ADD=00 SUB=01 AND=10 ORR=11
//   flags_q    out  [3:0] registered NZCV
//   illegal    out  one-cycle pulse in EXEC on an unsupported cmd
// -----------------------------------------------------------------------------
module mc_ctrl_unit #(
  parameter int ALU_CTRL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            alu_flags,
  output logic                  pc_we,
  output logic                  ir_we,
  output logic                  reg_we,
  output logic                  mem_we,
  output logic                  adr_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [3:0]            flags_q,
  output logic                  illegal
);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_CTRL_W-1:0] ALU_ORR = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9
  } state_t;

  state_t                  state_r;
  logic [3:0]              flags_r;

  logic [3:0]              cmd_s;
  logic                    cmd_legal_s;
  logic                    cmd_is_cmp_s;
  logic                    cmd_arith_s;
  logic [ALU_CTRL_W-1:0]   cmd_ctrl_s;
  logic                    cond_ex_s;
  logic                    in_exec_s;
  logic                    flag_upd_s;
  logic                    dp_wb_s;
  logic                    rd_is_pc_s;

  logic                    pc_we_s;
  logic                    ir_we_s;
  logic                    reg_we_s;
  logic                    mem_we_s;
  logic                    illegal_s;
  logic                    adr_src_s;
  logic                    alu_src_a_s;
  logic [1:0]              alu_src_b_s;
  logic [1:0]              result_src_s;
  logic [ALU_CTRL_W-1:0]   alu_ctrl_s;

  assign cmd_s      = funct[4:1];
  assign in_exec_s  = (state_r == S_EXEC_R) || (state_r == S_EXEC_I);
  assign rd_is_pc_s = (rd == 4'd15);

  // Data-processing cmd decode: ALU operation, legality, and whether C/V load.
  always_comb begin
    cmd_legal_s  = 1'b0;
    cmd_is_cmp_s = 1'b0;
    cmd_arith_s  = 1'b0;
    cmd_ctrl_s   = ALU_ADD;
    case (cmd_s)
      4'b0100: begin cmd_legal_s = 1'b1; cmd_arith_s = 1'b1; cmd_ctrl_s = ALU_ADD; end
      4'b0010: begin cmd_legal_s = 1'b1; cmd_arith_s = 1'b1; cmd_ctrl_s = ALU_SUB; end
      4'b0000: begin cmd_legal_s = 1'b1; cmd_arith_s = 1'b0; cmd_ctrl_s = ALU_AND; end
      4'b1100: begin cmd_legal_s = 1'b1; cmd_arith_s = 1'b0; cmd_ctrl_s = ALU_ORR; end
`ifdef CTRL_CMP_EN
      4'b1010: begin
        cmd_legal_s  = 1'b1;
        cmd_is_cmp_s = 1'b1;
        cmd_arith_s  = 1'b1;
        cmd_ctrl_s   = ALU_SUB;
      end
`endif
      default: begin
        cmd_legal_s = 1'b0;
        cmd_ctrl_s  = ALU_ADD;
      end
    endcase
  end

  // ARM condition evaluation against the registered NZCV ({N,Z,C,V}).
  always_comb begin
    cond_ex_s = 1'b0;
    case (cond)
      4'b0000: cond_ex_s =  flags_r[2];
      4'b0001: cond_ex_s = !flags_r[2];
      4'b0010: cond_ex_s =  flags_r[1];
      4'b0011: cond_ex_s = !flags_r[1];
      4'b0100: cond_ex_s =  flags_r[3];
      4'b0101: cond_ex_s = !flags_r[3];
      4'b0110: cond_ex_s =  flags_r[0];
      4'b0111: cond_ex_s = !flags_r[0];
      4'b1000: cond_ex_s =  flags_r[1] && !flags_r[2];
      4'b1001: cond_ex_s = !flags_r[1] ||  flags_r[2];
      4'b1010: cond_ex_s =  (flags_r[3] == flags_r[0]);
      4'b1011: cond_ex_s =  (flags_r[3] != flags_r[0]);
      4'b1100: cond_ex_s = !flags_r[2] && (flags_r[3] == flags_r[0]);
      4'b1101: cond_ex_s =  flags_r[2] || (flags_r[3] != flags_r[0]);
      default: cond_ex_s = 1'b1;
    endcase
  end

  // CMP sets flags without an S bit; unsupported cmds never touch flags.
  assign flag_upd_s = in_exec_s && cmd_legal_s && (funct[0] || cmd_is_cmp_s) && cond_ex_s;
  // Register/PC writeback of a data-processing result.
  assign dp_wb_s    = cond_ex_s && cmd_legal_s && !cmd_is_cmp_s;

  // Main control FSM state register and transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:  state_r <= S_DECODE;
        S_DECODE: begin
          case (op)
            2'b00:   state_r <= funct[5] ? S_EXEC_I : S_EXEC_R;
            2'b01:   state_r <= S_MEM_ADR;
            2'b10:   state_r <= S_BRANCH;
            default: state_r <= S_FETCH;
          endcase
        end
        S_EXEC_R:  state_r <= S_ALU_WB;
        S_EXEC_I:  state_r <= S_ALU_WB;
        S_ALU_WB:  state_r <= S_FETCH;
        S_MEM_ADR: state_r <= funct[0] ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  state_r <= S_MEM_WB;
        S_MEM_WB:  state_r <= S_FETCH;
        S_MEM_WR:  state_r <= S_FETCH;
        S_BRANCH:  state_r <= S_FETCH;
        default:   state_r <= S_FETCH;
      endcase
    end
  end

  // NZCV register: logical ops keep the previous C and V.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (flag_upd_s) begin
      flags_r[3:2] <= alu_flags[3:2];
      if (cmd_arith_s) begin
        flags_r[1:0] <= alu_flags[1:0];
      end
    end
  end

  // Moore output decode from the state register (enables gated by cond_ex).
  always_comb begin
    pc_we_s      = 1'b0;
    ir_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    mem_we_s     = 1'b0;
    illegal_s    = 1'b0;
    adr_src_s    = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    alu_ctrl_s   = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_we_s      = 1'b1;
        pc_we_s      = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_b_s = (state_r == S_EXEC_I) ? 2'b01 : 2'b00;
        alu_ctrl_s  = cmd_ctrl_s;
        illegal_s   = !cmd_legal_s;
      end
      S_ALU_WB: begin
        reg_we_s = dp_wb_s && !rd_is_pc_s;
        pc_we_s  = dp_wb_s &&  rd_is_pc_s;
      end
      S_MEM_ADR: begin
        alu_src_b_s = 2'b01;
        alu_ctrl_s  = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEM_RD: begin
        adr_src_s = 1'b1;
      end
      S_MEM_WB: begin
        result_src_s = 2'b01;
        reg_we_s     = cond_ex_s && !rd_is_pc_s;
        pc_we_s      = cond_ex_s &&  rd_is_pc_s;
      end
      S_MEM_WR: begin
        adr_src_s = 1'b1;
        mem_we_s  = cond_ex_s;
      end
      S_BRANCH: begin
        alu_src_b_s  = 2'b01;
        result_src_s = 2'b10;
        pc_we_s      = cond_ex_s;
      end
      default: begin
        alu_ctrl_s = ALU_ADD;
      end
    endcase
  end

  // Write enables and illegal are held low for the whole time reset is asserted.
  assign pc_we      = pc_we_s   && rst_n;
  assign ir_we      = ir_we_s   && rst_n;
  assign reg_we     = reg_we_s  && rst_n;
  assign mem_we     = mem_we_s  && rst_n;
  assign illegal    = illegal_s && rst_n;
  assign adr_src    = adr_src_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign result_src = result_src_s;
  assign imm_src    = op;
  assign alu_ctrl   = alu_ctrl_s;
  assign flags_q    = flags_r;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_unit
// Scoreboard bench for mc_ctrl_unit. For each instruction the expected
// per-cycle output vectors are pushed into a queue from an independent
// model of the control sequence, then popped and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_we, ir_we, reg_we, mem_we, adr_src, alu_src_a, illegal;
  logic [1:0] alu_src_b, result_src, imm_src, alu_ctrl;
  logic [3:0] flags_q;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_we;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] alu_ctrl;
    logic [3:0] flags_q;
    logic       illegal;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  logic [3:0] mf;          // model NZCV
  int checks;
  int failures;

  mc_ctrl_unit #(.ALU_CTRL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .mem_we(mem_we), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .flags_q(flags_q), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observe();
    exp_t o;
    o.pc_we = pc_we; o.ir_we = ir_we; o.reg_we = reg_we; o.mem_we = mem_we;
    o.adr_src = adr_src; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.result_src = result_src; o.imm_src = imm_src; o.alu_ctrl = alu_ctrl;
    o.flags_q = flags_q; o.illegal = illegal;
    return o;
  endfunction

  // Condition model: base test on cond[3:1], inverted by cond[0].
  function automatic logic cond_m(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return b ^ c[0];
  endfunction

  function automatic exp_t blank(input logic [1:0] o, input logic [3:0] f);
    exp_t e;
    e = '0;
    e.imm_src = o;
    e.flags_q = f;
    return e;
  endfunction

  // Build the expected cycle sequence of one instruction, then check limit entries (<0 = all).
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r, input logic [3:0] ef,
                           input int limit);
    exp_t e, got;
    string t;
    logic legal, cmp, arith, ok;
    logic [1:0] ctl;
    int n;
    cond = c; op = o; funct = f; rd = r; alu_flags = ef;
    e = blank(o, mf); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    e.ir_we = 1'b1; e.pc_we = 1'b1;
    exp_q.push_back(e); tag_q.push_back("fetch");
    e = blank(o, mf); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    exp_q.push_back(e); tag_q.push_back("decode");
    if (o == 2'b00) begin
      legal = 1'b1; cmp = 1'b0; arith = 1'b0; ctl = 2'b00;
      case (f[4:1])
        4'b0100: begin ctl = 2'b00; arith = 1'b1; end
        4'b0010: begin ctl = 2'b01; arith = 1'b1; end
        4'b0000: ctl = 2'b10;
        4'b1100: ctl = 2'b11;
`ifdef CTRL_CMP_EN
        4'b1010: begin ctl = 2'b01; arith = 1'b1; cmp = 1'b1; end
`endif
        default: legal = 1'b0;
      endcase
      e = blank(o, mf); e.alu_src_b = f[5] ? 2'b01 : 2'b00; e.alu_ctrl = ctl; e.illegal = ~legal;
      exp_q.push_back(e); tag_q.push_back("exec");
      if (legal && (f[0] || cmp) && cond_m(c, mf))
        mf = arith ? ef : {ef[3:2], mf[1:0]};
      ok = legal && !cmp && cond_m(c, mf);
      e = blank(o, mf); e.reg_we = ok && (r != 4'd15); e.pc_we = ok && (r == 4'd15);
      exp_q.push_back(e); tag_q.push_back("alu_wb");
    end else if (o == 2'b01) begin
      e = blank(o, mf); e.alu_src_b = 2'b01; e.alu_ctrl = f[3] ? 2'b00 : 2'b01;
      exp_q.push_back(e); tag_q.push_back("mem_adr");
      if (f[0]) begin
        e = blank(o, mf); e.adr_src = 1'b1;
        exp_q.push_back(e); tag_q.push_back("mem_rd");
        e = blank(o, mf); e.result_src = 2'b01;
        e.reg_we = cond_m(c, mf) && (r != 4'd15); e.pc_we = cond_m(c, mf) && (r == 4'd15);
        exp_q.push_back(e); tag_q.push_back("mem_wb");
      end else begin
        e = blank(o, mf); e.adr_src = 1'b1; e.mem_we = cond_m(c, mf);
        exp_q.push_back(e); tag_q.push_back("mem_wr");
      end
    end else if (o == 2'b10) begin
      e = blank(o, mf); e.alu_src_b = 2'b01; e.result_src = 2'b10; e.pc_we = cond_m(c, mf);
      exp_q.push_back(e); tag_q.push_back("branch");
    end
    n = 0;
    while (exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s/%s: got %b required %b", name, t, got, e);
      end
      n++;
      if (limit >= 0 && n >= limit) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cond = 4'd0; op = 2'd0; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
    mf = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({pc_we, ir_we, reg_we, mem_we, illegal} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_enables: got %b required 00000", {pc_we, ir_we, reg_we, mem_we, illegal});
    end
    checks++;
    if (flags_q !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000", flags_q);
    end
    checks++;
    if ({adr_src, alu_src_a, alu_src_b, result_src, alu_ctrl} !== 8'b0_1_10_10_00) begin
      failures++;
      $display("FAIL reset_selects: got %b required 01101000",
               {adr_src, alu_src_a, alu_src_b, result_src, alu_ctrl});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ir_we, pc_we} !== 2'b11) begin
      failures++;
      $display("FAIL release_fetch: got %b required 11", {ir_we, pc_we});
    end
  endtask

  task automatic test_add_r();
    run_instr("add_r", 4'b1110, 2'b00, 6'b001000, 4'd3, 4'b1111, -1);
    run_instr("orr_i", 4'b1110, 2'b00, 6'b111000, 4'd15, 4'b1111, -1);
  endtask

  task automatic test_subs_beq();
    run_instr("subs_z", 4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0100, -1);
    run_instr("beq_t",  4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    run_instr("subs_nz", 4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0000, -1);
    run_instr("beq_f",  4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
  endtask

  task automatic test_mem();
    run_instr("ldr_pc", 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, -1);
    run_instr("ldr_r5", 4'b1110, 2'b01, 6'b010001, 4'd5, 4'b0000, -1);
    run_instr("str_u0", 4'b1110, 2'b01, 6'b010000, 4'd1, 4'b0000, -1);
    run_instr("str_ne", 4'b0001, 2'b01, 6'b011000, 4'd1, 4'b0000, -1);
  endtask

  task automatic test_illegal();
    run_instr("adds_set", 4'b1110, 2'b00, 6'b001001, 4'd1, 4'b1011, -1);
    run_instr("cmd0001",  4'b1110, 2'b00, 6'b000011, 4'd1, 4'b0110, -1);
    run_instr("cmd1010",  4'b1110, 2'b00, 6'b010101, 4'd4, 4'b0101, -1);
    run_instr("ands_cv",  4'b1110, 2'b00, 6'b000001, 4'd6, 4'b1000, -1);
  endtask

  task automatic test_cond();
    logic [3:0] pats [5];
    pats[0] = 4'b0000; pats[1] = 4'b0100; pats[2] = 4'b1001;
    pats[3] = 4'b0010; pats[4] = 4'b1110;
    for (int p = 0; p < 5; p++) begin
      run_instr("cond_set", 4'b1110, 2'b00, 6'b001001, 4'd7, pats[p], -1);
      for (int c = 0; c < 16; c++)
        run_instr("cond_add", c[3:0], 2'b00, 6'b001000, 4'd8, 4'b0000, -1);
    end
  endtask

  task automatic test_back_to_back();
    run_instr("nop",  4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);
    run_instr("b_al", 4'b1110, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    run_instr("nop2", 4'b1110, 2'b11, 6'b111111, 4'd15, 4'b0000, -1);
    run_instr("sub",  4'b1110, 2'b00, 6'b000100, 4'd9, 4'b1111, -1);
  endtask

  task automatic test_reset_mid();
    run_instr("adds_pre", 4'b1110, 2'b00, 6'b001001, 4'd1, 4'b1100, -1);
    run_instr("add_wb",   4'b1110, 2'b00, 6'b001000, 4'd3, 4'b0000, 4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_we, pc_we, ir_we} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_we: got %b required 000", {reg_we, pc_we, ir_we});
    end
    checks++;
    if (flags_q !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_flags: got %b required 0000", flags_q);
    end
    exp_q.delete();
    tag_q.delete();
    mf = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("restart", 4'b1110, 2'b00, 6'b001000, 4'd3, 4'b0000, -1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add_r();
    test_subs_beq();
    test_mem();
    test_illegal();
    test_cond();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
